// File: rtl/adc_pll_supervisor.sv
// Reset and lock supervisor for the ADC clock PLL: pulses the PLL reset, qualifies lock,
// retries on timeout, and releases the PLL-domain reset only after a stable lock.
module adc_pll_supervisor #(
    parameter int RST_PULSE_CYC    = 10,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 7,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       adc_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [31:0]      C_MAX_RETRY = 32'(MAX_RETRIES);

    state_t           r_state;
    state_t           w_nxt;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_retry;
    logic [7:0]       r_loss;
    logic             r_pll_rst;
    logic             r_adc_rst_n;
    logic             r_ready;
    logic             r_fail;
    logic             w_locked_s;
    logic [2:0]       w_retry_inc;
    logic [2:0]       w_retry_nxt;
    logic [7:0]       w_loss_nxt;

    assign w_locked_s  = r_sync[1];
    assign w_retry_inc = (r_retry == 3'd7) ? r_retry : r_retry + 3'd1;

    always_comb begin
        w_nxt       = r_state;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        if (restart) begin
            w_nxt       = S_RESET;
            w_retry_nxt = '0;
            w_loss_nxt  = '0;
        end else begin
            case (r_state)
                S_RESET:  if (r_cnt == C_RST_LAST) w_nxt = S_WAIT;
                S_WAIT: begin
                    if (w_locked_s) begin
                        w_nxt = S_STABLE;
                    end else if (r_cnt == C_TO_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_nxt = ({29'd0, w_retry_inc} > C_MAX_RETRY) ? S_FAIL : S_RESET;
                    end
                end
                // A lock drop during qualification reopens the timeout window without a retry.
                S_STABLE: begin
                    if (!w_locked_s)               w_nxt = S_WAIT;
                    else if (r_cnt == C_STB_LAST)  w_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        w_nxt      = S_RESET;
                        w_loss_nxt = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                    end
                end
                S_FAIL:   w_nxt = S_FAIL;
                default:  w_nxt = S_RESET;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_adc_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], pll_locked};
            r_state     <= w_nxt;
            r_cnt       <= (restart || (w_nxt != r_state)) ? '0 : r_cnt + 1'b1;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_pll_rst   <= (w_nxt == S_RESET) || (w_nxt == S_FAIL);
            r_adc_rst_n <= (w_nxt == S_RUN);
            r_ready     <= (w_nxt == S_RUN);
            r_fail      <= (w_nxt == S_FAIL);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign adc_rst_n     = r_adc_rst_n;
    assign ready         = r_ready;
    assign fail          = r_fail;
    assign state         = r_state;
    assign retry_cnt     = r_retry;
    assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_adc_pll_supervisor.sv
// Bench for adc_pll_supervisor: directed vector table, hand sequences for bounce/loss/async
// reset, and randomized lock activity checked every cycle against a phase-level model.
module tb_adc_pll_supervisor;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       adc_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    adc_pll_supervisor #(
        .RST_PULSE_CYC(RP), .LOCK_TIMEOUT_CYC(TO), .LOCK_STABLE_CYC(ST),
        .MAX_RETRIES(MR), .CNT_W(16)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
        .pll_rst(pll_rst), .adc_rst_n(adc_rst_n), .ready(ready), .fail(fail),
        .state(state), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: current phase, cycles spent in it, counters, and the two-sample
    // history of pll_locked that the design's synchronizer sees.
    int m_ph, m_t, m_retry, m_loss;
    bit m_l1, m_l2;

    typedef struct {
        int    pre;
        int    lk;
        int    rs;
        int    n;
        int    st;
        int    prst;
        int    adc;
        int    fl;
        int    rty;
        string nm;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic m_reset();
        m_ph = 0; m_t = 0; m_retry = 0; m_loss = 0; m_l1 = 0; m_l2 = 0;
    endtask

    task automatic m_go(input int ph);
        m_ph = ph;
        m_t  = 0;
    endtask

    task automatic m_step();
        bit ls;
        ls   = m_l2;
        m_l2 = m_l1;
        m_l1 = pll_locked;
        if (restart) begin
            m_go(0); m_retry = 0; m_loss = 0;
            return;
        end
        m_t++;
        case (m_ph)
            0: if (m_t == RP) m_go(1);
            1: begin
                if (ls) m_go(2);
                else if (m_t == TO) begin
                    m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                    m_go((m_retry > MR) ? 4 : 0);
                end
            end
            2: begin
                if (!ls) m_go(1);
                else if (m_t == ST) m_go(3);
            end
            3: if (!ls) begin
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                m_go(0);
            end
            default: ;
        endcase
    endtask

    function automatic int m_vec();
        logic [17:0] v;
        v = {3'(m_ph), (m_ph == 0 || m_ph == 4), (m_ph == 3), (m_ph == 3), (m_ph == 4),
             3'(m_retry), 8'(m_loss)};
        return int'(v);
    endfunction

    function automatic int dut_vec();
        logic [17:0] v;
        v = {state, pll_rst, adc_rst_n, ready, fail, retry_cnt, lock_loss_cnt};
        return int'(v);
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input int lk, input int rs);
        pll_locked = (lk != 0);
        restart    = (rs != 0);
        @(posedge refclk);
        m_step();
        #1 chk("model", dut_vec(), m_vec());
        @(negedge refclk);
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_adc_rst_n"}, int'(adc_rst_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
        chk({tag, "_loss"}, int'(lock_loss_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
        m_reset();
        #1 chk_rst_vals("reset");
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic add(input int pre, lk, rs, n, st, prst, adc, fl, rty, input string nm);
        vec_t v;
        v.pre = pre; v.lk = lk; v.rs = rs; v.n = n; v.st = st;
        v.prst = prst; v.adc = adc; v.fl = fl; v.rty = rty; v.nm = nm;
        vecs.push_back(v);
    endtask

    initial begin
        int lk;
        int rate;
        m_reset();

        // pre  lk rs  n  st prst adc fl rty
        add(1, 0, 0,  3, 0, 1, 0, 0, 0, "s1_rst_hold");
        add(0, 0, 0,  1, 1, 0, 0, 0, 0, "s1_rst_fall");
        add(0, 0, 0,  9, 1, 0, 0, 0, 0, "s1_wait");
        add(0, 1, 0, 10, 2, 0, 0, 0, 0, "s1_qual");
        add(0, 1, 0,  1, 3, 0, 1, 0, 0, "s1_run");
        add(1, 0, 0,  4, 1, 0, 0, 0, 0, "s2_w1");
        add(0, 0, 0, 19, 1, 0, 0, 0, 0, "s2_w1_end");
        add(0, 0, 0,  1, 0, 1, 0, 0, 1, "s2_to1");
        add(0, 0, 0,  4, 1, 0, 0, 0, 1, "s2_w2");
        add(0, 0, 0, 20, 0, 1, 0, 0, 2, "s2_to2");
        add(0, 0, 0,  4, 1, 0, 0, 0, 2, "s2_w3");
        add(0, 0, 0, 20, 4, 1, 0, 1, 3, "s2_fail");
        add(0, 0, 0,  6, 4, 1, 0, 1, 3, "s2_hold");
        add(0, 1, 1,  1, 0, 1, 0, 0, 0, "s5_restart");
        add(0, 1, 0,  4, 1, 0, 0, 0, 0, "s5_wait");
        add(0, 1, 0,  1, 2, 0, 0, 0, 0, "s5_stable");
        add(0, 1, 0,  7, 2, 0, 0, 0, 0, "s5_qual");
        add(0, 1, 0,  1, 3, 0, 1, 0, 0, "s5_run");

        @(negedge refclk);
        foreach (vecs[i]) begin
            if (vecs[i].pre != 0) do_reset();
            repeat (vecs[i].n) tick(vecs[i].lk, vecs[i].rs);
            chk({vecs[i].nm, "_state"}, int'(state), vecs[i].st);
            chk({vecs[i].nm, "_pll_rst"}, int'(pll_rst), vecs[i].prst);
            chk({vecs[i].nm, "_adc_rst_n"}, int'(adc_rst_n), vecs[i].adc);
            chk({vecs[i].nm, "_ready"}, int'(ready), vecs[i].adc);
            chk({vecs[i].nm, "_fail"}, int'(fail), vecs[i].fl);
            chk({vecs[i].nm, "_retry"}, int'(retry_cnt), vecs[i].rty);
        end

        // Lock bounce: locked_s low while the stable counter reads 5.
        do_reset();
        repeat (8) tick(1, 0);
        chk("s3_stable", int'(state), 2);
        tick(0, 0);
        tick(1, 0);
        chk("s3_pre_bounce", int'(state), 2);
        tick(1, 0);
        chk("s3_bounce", int'(state), 1);
        chk("s3_retry", int'(retry_cnt), 0);
        tick(1, 0);
        chk("s3_requal", int'(state), 2);
        repeat (7) tick(1, 0);
        chk("s3_not_yet", int'(adc_rst_n), 0);
        tick(1, 0);
        chk("s3_run", int'(adc_rst_n), 1);

        // Lock loss in RUN: reset asserted on the third edge.
        repeat (2) tick(0, 0);
        chk("s4_hold_adc", int'(adc_rst_n), 1);
        tick(0, 0);
        chk("s4_loss_adc", int'(adc_rst_n), 0);
        chk("s4_loss_pll", int'(pll_rst), 1);
        chk("s4_loss_cnt", int'(lock_loss_cnt), 1);
        repeat (13) tick(1, 0);
        chk("s4_relock", int'(state), 3);
        chk("s4_relock_loss", int'(lock_loss_cnt), 1);

        // Async reset while in STABLE, between clock edges.
        repeat (3) tick(0, 0);
        chk("s6_loss2", int'(lock_loss_cnt), 2);
        repeat (5) tick(1, 0);
        chk("s6_stable", int'(state), 2);
        #2 rst_n = 1'b0;
        m_reset();
        #1 chk_rst_vals("s6_async");
        @(negedge refclk);
        rst_n = 1'b1;
        pll_locked = 1'b0;

        // Randomized lock activity with varying toggle rates and rare restarts.
        lk = 0;
        for (int seg = 0; seg < 8; seg++) begin
            if (seg % 4 == 0) do_reset();
            case ($urandom_range(3))
                0:       rate = 3;
                1:       rate = 12;
                2:       rate = 40;
                default: rate = 200;
            endcase
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(rate - 1) == 0) lk = 1 - lk;
                tick(lk, ($urandom_range(299) == 0) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
